// File: rtl/hc_lane_dispatch.sv
// hc_lane_dispatch
// ----------------
// Fan-out/fan-in stage between the line requestor and a bank of identical
// streaming compute lanes. Accepted lines are handed out round-robin across
// the active lanes. Results are gathered back in input order through one
// small FIFO per lane. Each lane holds FIFO_DEPTH credits, so its FIFO can
// never be overrun by results the lane was legitimately asked for.
//
// Ports
//   clk, reset       single clock, asynchronous active-high reset
//   num_active       requested lane count (0 or >NUM_LANES means all),
//                    taken only while idle
//   data_in/valid_in/ready_in          input line handshake
//   lane_data_out/lane_valid_out       registered line + strobe per lane
//   lane_data_in/lane_valid_in         result + strobe from each lane
//   data_out/valid_out/ready_out       ordered result stream
//   idle             no line in flight or buffered
//   overflow_err     sticky: a lane result arrived at a full FIFO
//   lines_in, stall_cycles             saturating statistics
//
// Build option
//   HC_DISPATCH_STATS_EN  when defined, lines_in counts accepted lines and
//                         stall_cycles counts cycles with valid_in && !ready_in.
//                         When undefined both outputs are constant zero.

module hc_lane_dispatch #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [$clog2(NUM_LANES+1)-1:0]        num_active,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    input  logic                                  valid_in,
    output logic                                  ready_in,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_data_out,
    output logic [NUM_LANES-1:0]                  lane_valid_out,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_data_in,
    input  logic [NUM_LANES-1:0]                  lane_valid_in,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  valid_out,
    input  logic                                  ready_out,
    output logic                                  idle,
    output logic                                  overflow_err,
    output logic [31:0]                           lines_in,
    output logic [31:0]                           stall_cycles
);

    localparam int NA_W = $clog2(NUM_LANES + 1);
    localparam int PW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0]   FULL_CREDIT = CW'(FIFO_DEPTH);
    localparam logic [AW:0]     FIFO_FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [NA_W-1:0] MAX_N       = NA_W'(NUM_LANES);

    logic [NA_W-1:0]       n_q, n_new, n_cur;
    logic                  n_chg;
    logic [PW-1:0]         dp_q, cp_q, dp_cur;
    logic [CW-1:0]         credit [NUM_LANES];
    logic [DATA_WIDTH-1:0] mem    [NUM_LANES][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr [NUM_LANES];
    logic [AW-1:0]         rd_ptr [NUM_LANES];
    logic [AW:0]           cnt    [NUM_LANES];
    logic                  accept, pop;
    logic [NUM_LANES-1:0]  lane_en, push, pop_lane, disp_lane, drop;

    // Pointer step with wrap at the current lane count.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p,
                                              input logic [NA_W-1:0] n);
        if (int'(p) + 1 >= int'(n))
            return '0;
        else
            return p + 1'b1;
    endfunction

    // Lane count bookkeeping. A new count is only taken while idle; when it
    // differs from the held one the pointers restart at lane 0 so they can
    // never point past the new count. Since idle means every FIFO is empty
    // and every credit is home, the restart cannot disturb ordering.
    always_comb begin
        n_new = (num_active == '0 || int'(num_active) > NUM_LANES) ? MAX_N : num_active;
        for (int i = 0; i < NUM_LANES; i++)
            lane_en[i] = (i < int'(n_q));
        idle = 1'b1;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_en[i] && credit[i] != FULL_CREDIT)
                idle = 1'b0;
        n_chg  = idle && (n_new != n_q);
        n_cur  = idle ? n_new : n_q;
        dp_cur = n_chg ? '0 : dp_q;
    end

    // Handshakes and per-lane events. ready_in looks at dp_q rather than
    // dp_cur: in the only case they differ (idle) every credit is full, and
    // this keeps num_active out of the ready_in path.
    always_comb begin
        ready_in  = (credit[dp_q] != '0);
        accept    = valid_in && ready_in;
        valid_out = (cnt[cp_q] != '0);
        pop       = valid_out && ready_out;
        data_out  = valid_out ? mem[cp_q][rd_ptr[cp_q]] : '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            disp_lane[i] = accept && (dp_cur == PW'(i));
            pop_lane[i]  = pop && (cp_q == PW'(i));
            push[i]      = lane_valid_in[i] && lane_en[i] && (cnt[i] != FIFO_FULL);
            drop[i]      = lane_valid_in[i] && lane_en[i] && (cnt[i] == FIFO_FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q            <= MAX_N;
            dp_q           <= '0;
            cp_q           <= '0;
            lane_valid_out <= '0;
            lane_data_out  <= '0;
            overflow_err   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                credit[i] <= FULL_CREDIT;
                cnt[i]    <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            n_q            <= n_cur;
            dp_q           <= accept ? advance(dp_cur, n_cur) : dp_cur;
            cp_q           <= n_chg ? '0 : (pop ? advance(cp_q, n_q) : cp_q);
            lane_valid_out <= disp_lane;
            if (accept)
                lane_data_out[dp_cur] <= data_in;
            if (|drop)
                overflow_err <= 1'b1;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (disp_lane[i] && !pop_lane[i])
                    credit[i] <= credit[i] - 1'b1;
                else if (!disp_lane[i] && pop_lane[i])
                    credit[i] <= credit[i] + 1'b1;
                if (push[i] && !pop_lane[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!push[i] && pop_lane[i])
                    cnt[i] <= cnt[i] - 1'b1;
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_lane[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: the occupancy counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (push[i])
                mem[i][wr_ptr[i]] <= lane_data_in[i];
    end

`ifdef HC_DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_in     <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept && lines_in != '1)
                lines_in <= lines_in + 1'b1;
            if (valid_in && !ready_in && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    assign lines_in     = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hc_lane_dispatch.sv
// Directed bench for hc_lane_dispatch. External lanes are modelled as
// delay lines (per-lane latency) that return line + 256.

module tb_hc_lane_dispatch;

    localparam int DW = 512;
    localparam int NL = 4;

    logic                   clk;
    logic                   reset;
    logic [2:0]             num_active;
    logic [DW-1:0]          data_in;
    logic                   valid_in;
    logic                   ready_in;
    logic [NL-1:0][DW-1:0]  lane_data_out;
    logic [NL-1:0]          lane_valid_out;
    logic [NL-1:0][DW-1:0]  lane_data_in;
    logic [NL-1:0]          lane_valid_in;
    logic [DW-1:0]          data_out;
    logic                   valid_out;
    logic                   ready_out;
    logic                   idle;
    logic                   overflow_err;
    logic [31:0]            lines_in;
    logic [31:0]            stall_cycles;

    int tests_run    = 0;
    int tests_failed = 0;

    hc_lane_dispatch #(.DATA_WIDTH(DW), .NUM_LANES(NL), .FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .num_active     (num_active),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .lane_data_out  (lane_data_out),
        .lane_valid_out (lane_valid_out),
        .lane_data_in   (lane_data_in),
        .lane_valid_in  (lane_valid_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .idle           (idle),
        .overflow_err   (overflow_err),
        .lines_in       (lines_in),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Lane model: strobe in cycle t returns line+256 in cycle t+lat.
    int            lat [NL] = '{3, 3, 3, 3};
    logic [7:0]    pv  [NL];
    logic [DW-1:0] pd  [NL][8];
    logic [NL-1:0] force_valid = '0;
    logic [DW-1:0] force_data  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) pv[i] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) pv[i] <= {pv[i][6:0], lane_valid_out[i]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            for (int k = 7; k > 0; k--) pd[i][k] <= pd[i][k-1];
            pd[i][0] <= lane_data_out[i] + DW'(256);
        end
    end

    always_comb begin
        lane_valid_in = '0;
        lane_data_in  = '0;
        for (int i = 0; i < NL; i++) begin
            lane_valid_in[i] = pv[i][lat[i]-1] | force_valid[i];
            lane_data_in[i]  = force_valid[i] ? force_data : pd[i][lat[i]-1];
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [DW-1:0] got [$];
    int            pop_cyc [$];
    int            first_acc = -1;
    logic [NL-1:0] strobe_mask = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_in && ready_in && first_acc < 0) first_acc = cyc;
            if (valid_out && ready_out) begin
                got.push_back(data_out);
                pop_cyc.push_back(cyc);
            end
            strobe_mask = strobe_mask | lane_valid_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one line and hold it until accepted; returns #1 after the accept edge.
    task automatic applyStimulus(input int val);
        int guard = 0;
        valid_in = 1'b1;
        data_in  = DW'(val);
        @(negedge clk);
        while (!ready_in && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_in) checkOutput("send_timeout", DW'(ready_in), DW'(1));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic waitPops(input string tag, input int n);
        int guard = 0;
        while (got.size() < n && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput(tag, DW'(got.size()), DW'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic checkStream(input string tag, input int n);
        for (int k = 0; k < n; k++)
            checkOutput(tag, (k < got.size()) ? got[k] : 'x, DW'(k + 256));
    endtask

    task automatic clearMonitor();
        got.delete();
        pop_cyc.delete();
        strobe_mask = '0;
        first_acc   = -1;
    endtask

    initial begin
        reset      = 1'b0;
        num_active = 3'd4;
        data_in    = '0;
        valid_in   = 1'b0;
        ready_out  = 1'b1;
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_ready_in",   DW'(ready_in), DW'(1));
        checkOutput("rst_lane_valid", DW'(lane_valid_out), DW'(0));
        checkOutput("rst_lane_data",  DW'(|lane_data_out), DW'(0));
        checkOutput("rst_valid_out",  DW'(valid_out), DW'(0));
        checkOutput("rst_data_out",   data_out, DW'(0));
        checkOutput("rst_idle",       DW'(idle), DW'(1));
        checkOutput("rst_overflow",   DW'(overflow_err), DW'(0));
        checkOutput("rst_lines_in",   DW'(lines_in), DW'(0));
        checkOutput("rst_stalls",     DW'(stall_cycles), DW'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Sixteen back-to-back lines, latency 3 on every lane.
        clearMonitor();
        applyStimulus(0);
        checkOutput("t1_strobe0", DW'(lane_valid_out), DW'(4'b0001));
        applyStimulus(1);
        checkOutput("t1_strobe1", DW'(lane_valid_out), DW'(4'b0010));
        checkOutput("t1_lane1_data", lane_data_out[1], DW'(1));
        for (int k = 2; k < 16; k++) applyStimulus(k);
        waitPops("t1_drain", 16);
        checkStream("t1_order", 16);
        checkOutput("t1_latency", DW'(pop_cyc[0] - first_acc), DW'(5));
        checkOutput("t1_no_bubble", DW'(pop_cyc[15] - pop_cyc[0]), DW'(15));
        checkOutput("t1_idle", DW'(idle), DW'(1));

        // Mixed lane latencies: order must survive.
        lat = '{1, 7, 2, 5};
        clearMonitor();
        for (int k = 0; k < 16; k++) applyStimulus(k);
        checkOutput("t2_busy", DW'(idle), DW'(0));
        waitPops("t2_drain", 16);
        checkStream("t2_order", 16);
        checkOutput("t2_idle", DW'(idle), DW'(1));
        lat = '{3, 3, 3, 3};

        // Consumer stalled, continuous input: credits limit to 32 accepts.
        reset = 1'b1;
        #1 reset = 1'b0;
        clearMonitor();
        ready_out = 1'b0;
        begin
            int nacc = 0;
            for (int c = 0; c < 40; c++) begin
                valid_in = 1'b1;
                data_in  = DW'(nacc);
                @(negedge clk);
                if (ready_in) nacc++;
                @(posedge clk);
                #1;
            end
            valid_in = 1'b0;
            checkOutput("t3_accepts", DW'(nacc), DW'(32));
        end
        checkOutput("t3_ready_low", DW'(ready_in), DW'(0));
        checkOutput("t3_valid_out", DW'(valid_out), DW'(1));
        checkOutput("t3_head", data_out, DW'(256));
`ifdef HC_DISPATCH_STATS_EN
        checkOutput("t3_lines_in", DW'(lines_in), DW'(32));
        checkOutput("t3_stalls", DW'(stall_cycles), DW'(8));
`else
        checkOutput("t3_lines_in", DW'(lines_in), DW'(0));
        checkOutput("t3_stalls", DW'(stall_cycles), DW'(0));
`endif

        // Extra result into the full lane-1 FIFO.
        checkOutput("t5_ovf_before", DW'(overflow_err), DW'(0));
        force_data     = DW'(16'hDEAD);
        force_valid[1] = 1'b1;
        @(posedge clk);
        #1 force_valid[1] = 1'b0;
        checkOutput("t5_ovf_set", DW'(overflow_err), DW'(1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_ovf_sticky", DW'(overflow_err), DW'(1));
        ready_out = 1'b1;
        waitPops("t5_drain", 32);
        checkStream("t5_order", 32);
        checkOutput("t5_idle", DW'(idle), DW'(1));

        // Lane count change while busy is deferred until idle.
        clearMonitor();
        applyStimulus(0);
        num_active = 3'd2;
        for (int k = 1; k < 8; k++) applyStimulus(k);
        waitPops("t4_drain_a", 8);
        checkStream("t4_order_a", 8);
        checkOutput("t4_mask_busy", DW'(strobe_mask), DW'(4'b1111));
        repeat (2) @(posedge clk);
        #1 clearMonitor();
        for (int k = 0; k < 6; k++) applyStimulus(k);
        waitPops("t4_drain_b", 6);
        checkStream("t4_order_b", 6);
        checkOutput("t4_mask_two", DW'(strobe_mask), DW'(4'b0011));
        num_active = 3'd0;
        repeat (2) @(posedge clk);
        #1 clearMonitor();
        for (int k = 0; k < 8; k++) applyStimulus(k);
        waitPops("t4_drain_c", 8);
        checkStream("t4_order_c", 8);
        checkOutput("t4_mask_zero", DW'(strobe_mask), DW'(4'b1111));

        // Reset with ten lines in flight.
        ready_out = 1'b0;
        for (int k = 0; k < 10; k++) applyStimulus(100 + k);
        checkOutput("t6_strobe_live", DW'(lane_valid_out), DW'(4'b0010));
        reset = 1'b1;
        #1;
        checkOutput("t6_lane_valid", DW'(lane_valid_out), DW'(0));
        checkOutput("t6_lane_data",  DW'(|lane_data_out), DW'(0));
        checkOutput("t6_valid_out",  DW'(valid_out), DW'(0));
        checkOutput("t6_data_out",   data_out, DW'(0));
        checkOutput("t6_ready_in",   DW'(ready_in), DW'(1));
        checkOutput("t6_idle",       DW'(idle), DW'(1));
        checkOutput("t6_overflow",   DW'(overflow_err), DW'(0));
        checkOutput("t6_lines_in",   DW'(lines_in), DW'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        clearMonitor();
        ready_out = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(k);
        waitPops("t6_drain", 4);
        checkStream("t6_order", 4);
        checkOutput("t6_no_extra", DW'(got.size()), DW'(4));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
